// File: rtl/store_drain_buffer_if.sv
// Retire-side, D-cache write-side and store-queue ack signals of the store drain buffer.
// The slave modport is the buffer itself; master is whatever surrounds it.
interface store_drain_buffer_if #(
  parameter int N_WAY    = 2,
  parameter int DEPTH    = 8,
  parameter int XLEN     = 32,
  parameter int SQ_IDX_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [N_WAY-1:0]          ret_valid;
  logic [N_WAY*XLEN-1:0]     ret_addr;
  logic [N_WAY*XLEN-1:0]     ret_data;
  logic [N_WAY*2-1:0]        ret_size;
  logic [N_WAY*SQ_IDX_W-1:0] ret_pos;
  logic [CNT_W-1:0]          free_slots;

  logic                      dc_wr_valid;
  logic [XLEN-1:0]           dc_wr_addr;
  logic [XLEN-1:0]           dc_wr_data;
  logic [3:0]                dc_wr_be;
  logic                      dc_wr_ready;

  logic                      sq_ack_valid;
  logic [SQ_IDX_W-1:0]       sq_ack_pos;
  logic                      misalign_err;
  logic                      overflow_err;

  modport slave (
    input  ret_valid, ret_addr, ret_data, ret_size, ret_pos, dc_wr_ready,
    output free_slots, dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_be,
           sq_ack_valid, sq_ack_pos, misalign_err, overflow_err
  );

  modport master (
    output ret_valid, ret_addr, ret_data, ret_size, ret_pos, dc_wr_ready,
    input  free_slots, dc_wr_valid, dc_wr_addr, dc_wr_data, dc_wr_be,
           sq_ack_valid, sq_ack_pos, misalign_err, overflow_err
  );
endinterface

// File: rtl/store_drain_buffer.sv
// In-order FIFO between store-queue retire and the D-cache write port. Entries are
// stored already lane-formatted, so the drain side is a plain register read.
module store_drain_buffer #(
  parameter int N_WAY    = 2,
  parameter int DEPTH    = 8,
  parameter int XLEN     = 32,
  parameter int SQ_IDX_W = 4
) (
  input logic                 clock,
  input logic                 reset_n,
  store_drain_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]     addr_q [DEPTH];
  logic [XLEN-1:0]     addr_d [DEPTH];
  logic [XLEN-1:0]     data_q [DEPTH];
  logic [XLEN-1:0]     data_d [DEPTH];
  logic [3:0]          be_q   [DEPTH];
  logic [3:0]          be_d   [DEPTH];
  logic [SQ_IDX_W-1:0] pos_q  [DEPTH];
  logic [SQ_IDX_W-1:0] pos_d  [DEPTH];

  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d, slot;
  logic [CNT_W-1:0]    count_q, count_d, free_slots, accepted;
  logic                ack_valid_q, ack_valid_d;
  logic [SQ_IDX_W-1:0] ack_pos_q, ack_pos_d;
  logic                misalign_q, misalign_d, overflow_q, overflow_d;
  logic                fire, dc_valid;
  logic [XLEN-1:0]     way_addr, way_data;
  logic [1:0]          way_size;
  logic                way_bad;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return off != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_data(input logic [1:0] size, input logic [XLEN-1:0] d);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign dc_valid   = count_q != '0;

  // Compact valid ways into the tail, limited by the registered free count.
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    be_d       = be_q;
    pos_d      = pos_q;
    misalign_d = misalign_q;
    overflow_d = overflow_q;
    accepted   = '0;
    slot       = '0;
    way_addr   = '0;
    way_data   = '0;
    way_size   = '0;
    way_bad    = 1'b0;
    for (int w = 0; w < N_WAY; w++) begin
      way_addr = bus.ret_addr[w*XLEN +: XLEN];
      way_data = bus.ret_data[w*XLEN +: XLEN];
      way_size = bus.ret_size[w*2 +: 2];
      way_bad  = is_misaligned(way_size, way_addr[1:0]);
      if (bus.ret_valid[w]) begin
        if (way_bad) misalign_d = 1'b1;
        if (accepted < free_slots) begin
          slot         = tail_q + accepted[PTR_W-1:0];
          addr_d[slot] = {way_addr[XLEN-1:2], 2'b00};
          data_d[slot] = lane_data(way_size, way_data);
          be_d[slot]   = way_bad ? 4'h0 : lane_be(way_size, way_addr[1:0]);
          pos_d[slot]  = bus.ret_pos[w*SQ_IDX_W +: SQ_IDX_W];
          accepted     = accepted + 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end

    fire        = dc_valid & bus.dc_wr_ready;
    head_d      = head_q + PTR_W'(fire);
    tail_d      = tail_q + accepted[PTR_W-1:0];
    count_d     = count_q + accepted - CNT_W'(fire);
    ack_valid_d = fire;
    ack_pos_d   = fire ? pos_q[head_q] : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
        pos_q[i]  <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ack_valid_q <= 1'b0;
      ack_pos_q   <= '0;
      misalign_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
        be_q[i]   <= be_d[i];
        pos_q[i]  <= pos_d[i];
      end
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ack_valid_q <= ack_valid_d;
      ack_pos_q   <= ack_pos_d;
      misalign_q  <= misalign_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.free_slots   = free_slots;
  assign bus.dc_wr_valid  = dc_valid;
  assign bus.dc_wr_addr   = dc_valid ? addr_q[head_q] : '0;
  assign bus.dc_wr_data   = dc_valid ? data_q[head_q] : '0;
  assign bus.dc_wr_be     = dc_valid ? be_q[head_q] : '0;
  assign bus.sq_ack_valid = ack_valid_q;
  assign bus.sq_ack_pos   = ack_pos_q;
  assign bus.misalign_err = misalign_q;
  assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: a queue-based reference model checked every cycle,
// plus a vector table and directed multi-cycle sequences.
module tb_store_drain_buffer;
  localparam int N_WAY = 2, DEPTH = 8, XLEN = 32, SQ_IDX_W = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  store_drain_buffer_if #(.N_WAY(N_WAY), .DEPTH(DEPTH), .XLEN(XLEN), .SQ_IDX_W(SQ_IDX_W)) bus ();

  store_drain_buffer #(.N_WAY(N_WAY), .DEPTH(DEPTH), .XLEN(XLEN), .SQ_IDX_W(SQ_IDX_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [3:0]  pos;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [3:0]  pos;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic        exp_mis;
  } vec_t;

  ent_t       mq[$];
  logic [3:0] accept_log[$];
  logic [3:0] ack_log[$];
  logic       exp_ack_valid = 1'b0;
  logic [3:0] exp_ack_pos   = '0;
  logic       exp_mis       = 1'b0;
  logic       exp_ovf       = 1'b0;
  int         pass_count    = 0;
  int         check_count   = 0;
  vec_t       vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic model_bad(input logic [31:0] addr, input logic [1:0] size);
    int o;
    o = int'(addr % 4);
    return (size == 2'd3) || (size == 2'd1 && (o % 2) != 0) || (size == 2'd2 && o != 0);
  endfunction

  function automatic ent_t model_entry(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [1:0] size, input logic [3:0] pos);
    ent_t e;
    int o;
    o      = int'(addr % 4);
    e.addr = addr - 32'(o);
    e.pos  = pos;
    e.be   = 4'h0;
    e.data = 32'h0;
    if (!model_bad(addr, size)) begin
      case (size)
        2'd0: begin e.be = 4'(1 << o); e.data = (data & 32'hFF) * 32'h01010101; end
        2'd1: begin e.be = 4'(3 << o); e.data = (data & 32'hFFFF) * 32'h00010001; end
        default: begin e.be = 4'hF; e.data = data; end
      endcase
    end
    return e;
  endfunction

  task automatic apply_stimulus(input int w, input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size, input logic [3:0] pos);
    bus.ret_valid[w]               = 1'b1;
    bus.ret_addr[w*XLEN +: XLEN]   = addr;
    bus.ret_data[w*XLEN +: XLEN]   = data;
    bus.ret_size[w*2 +: 2]         = size;
    bus.ret_pos[w*SQ_IDX_W +: SQ_IDX_W] = pos;
  endtask

  task automatic clear_ways();
    bus.ret_valid = '0;
    bus.ret_addr  = '0;
    bus.ret_data  = '0;
    bus.ret_size  = '0;
    bus.ret_pos   = '0;
  endtask

  task automatic check_output();
    check("free_slots", 32'(bus.free_slots), 32'(DEPTH - mq.size()));
    check("dc_wr_valid", 32'(bus.dc_wr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("dc_wr_addr", bus.dc_wr_addr, mq[0].addr);
      check("dc_wr_be", 32'(bus.dc_wr_be), 32'(mq[0].be));
      if (mq[0].be != 4'h0) check("dc_wr_data", bus.dc_wr_data, mq[0].data);
    end
    check("sq_ack_valid", 32'(bus.sq_ack_valid), 32'(exp_ack_valid));
    if (exp_ack_valid) check("sq_ack_pos", 32'(bus.sq_ack_pos), 32'(exp_ack_pos));
    check("misalign_err", 32'(bus.misalign_err), 32'(exp_mis));
    check("overflow_err", 32'(bus.overflow_err), 32'(exp_ovf));
  endtask

  // Reference behaviour at a rising edge, using the inputs the bench is driving.
  task automatic model_update();
    int   free;
    int   acc;
    ent_t e;
    if (!reset_n) begin
      mq.delete();
      exp_ack_valid = 1'b0;
      exp_ack_pos   = '0;
      exp_mis       = 1'b0;
      exp_ovf       = 1'b0;
      return;
    end
    free          = DEPTH - mq.size();
    exp_ack_valid = (mq.size() != 0) && bus.dc_wr_ready;
    if (exp_ack_valid) begin
      exp_ack_pos = mq[0].pos;
      void'(mq.pop_front());
    end
    acc = 0;
    for (int w = 0; w < N_WAY; w++) begin
      if (bus.ret_valid[w]) begin
        e = model_entry(bus.ret_addr[w*XLEN +: XLEN], bus.ret_data[w*XLEN +: XLEN],
                        bus.ret_size[w*2 +: 2], bus.ret_pos[w*SQ_IDX_W +: SQ_IDX_W]);
        if (model_bad(bus.ret_addr[w*XLEN +: XLEN], bus.ret_size[w*2 +: 2])) exp_mis = 1'b1;
        if (acc < free) begin
          mq.push_back(e);
          accept_log.push_back(e.pos);
          acc++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    check_output();
    if (bus.sq_ack_valid) ack_log.push_back(bus.sq_ack_pos);
    model_update();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_ways();
    bus.dc_wr_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    ack_log.delete();
    accept_log.delete();
  endtask

  initial begin
    vecs[0] = '{32'h1003, 32'h000000AB, 2'd0, 4'd5, 32'h1000, 32'hABABABAB, 4'b1000, 1'b0};
    vecs[1] = '{32'h2002, 32'h00001234, 2'd1, 4'd3, 32'h2000, 32'h12341234, 4'b1100, 1'b0};
    vecs[2] = '{32'h2000, 32'hDEADBEEF, 2'd2, 4'd2, 32'h2000, 32'hDEADBEEF, 4'b1111, 1'b0};
    vecs[3] = '{32'h0040, 32'h000001FF, 2'd0, 4'd1, 32'h0040, 32'hFFFFFFFF, 4'b0001, 1'b0};
    vecs[4] = '{32'h3001, 32'h00005678, 2'd1, 4'd7, 32'h3000, 32'h0,        4'b0000, 1'b1};
    vecs[5] = '{32'h0044, 32'h12345678, 2'd3, 4'd9, 32'h0044, 32'h0,        4'b0000, 1'b1};

    clear_ways();
    bus.dc_wr_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    check("reset_free_slots", 32'(bus.free_slots), 32'd8);
    check("reset_dc_wr_valid", 32'(bus.dc_wr_valid), 32'd0);
    check("reset_dc_wr_addr", bus.dc_wr_addr, 32'd0);
    check("reset_dc_wr_data", bus.dc_wr_data, 32'd0);
    check("reset_dc_wr_be", 32'(bus.dc_wr_be), 32'd0);
    check("reset_sq_ack_valid", 32'(bus.sq_ack_valid), 32'd0);
    check("reset_misalign_err", 32'(bus.misalign_err), 32'd0);
    check("reset_overflow_err", 32'(bus.overflow_err), 32'd0);

    // Table: single store, ready held high; head next cycle, ack the one after.
    for (int i = 0; i < 6; i++) begin
      clear_ways();
      apply_stimulus(0, vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].pos);
      bus.dc_wr_ready = 1'b1;
      tick();
      clear_ways();
      check("vec_valid", 32'(bus.dc_wr_valid), 32'd1);
      check("vec_addr", bus.dc_wr_addr, vecs[i].exp_addr);
      check("vec_be", 32'(bus.dc_wr_be), 32'(vecs[i].exp_be));
      if (vecs[i].exp_be != 4'h0) check("vec_data", bus.dc_wr_data, vecs[i].exp_data);
      tick();
      check("vec_ack_valid", 32'(bus.sq_ack_valid), 32'd1);
      check("vec_ack_pos", 32'(bus.sq_ack_pos), 32'(vecs[i].pos));
      check("vec_misalign", 32'(bus.misalign_err), 32'(vecs[i].exp_mis));
      tick();
    end

    // Back-pressure: outputs hold while ready is low, then exactly one ack.
    do_reset();
    apply_stimulus(0, 32'h2000, 32'hDEADBEEF, 2'd2, 4'd2);
    tick();
    clear_ways();
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(bus.dc_wr_valid), 32'd1);
      check("bp_addr", bus.dc_wr_addr, 32'h2000);
      check("bp_data", bus.dc_wr_data, 32'hDEADBEEF);
      check("bp_no_ack", 32'(bus.sq_ack_valid), 32'd0);
      tick();
    end
    bus.dc_wr_ready = 1'b1;
    tick();
    check("bp_ack_valid", 32'(bus.sq_ack_valid), 32'd1);
    check("bp_ack_pos", 32'(bus.sq_ack_pos), 32'd2);
    tick();
    check("bp_single_ack", 32'(bus.sq_ack_valid), 32'd0);

    // Fill to capacity, then an extra pair is dropped.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      clear_ways();
      apply_stimulus(0, 32'h100 + 32'(8 * c), 32'(c), 2'd2, 4'(2 * c + 1));
      apply_stimulus(1, 32'h104 + 32'(8 * c), 32'(c), 2'd2, 4'(2 * c + 2));
      tick();
    end
    clear_ways();
    check("fill_free_zero", 32'(bus.free_slots), 32'd0);
    apply_stimulus(0, 32'h200, 32'h1, 2'd2, 4'd9);
    apply_stimulus(1, 32'h204, 32'h2, 2'd2, 4'd10);
    tick();
    clear_ways();
    check("fill_overflow", 32'(bus.overflow_err), 32'd1);
    check("fill_still_full", 32'(bus.free_slots), 32'd0);
    bus.dc_wr_ready = 1'b1;
    repeat (10) tick();
    check("fill_ack_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < ack_log.size() && i < 8; i++)
      check("fill_ack_order", 32'(ack_log[i]), 32'(i + 1));

    // Wrap-around stream with ready toggling.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      clear_ways();
      apply_stimulus(0, 32'h4000 + 32'(8 * c), $urandom, 2'd2, 4'(((2 * c) % 15) + 1));
      apply_stimulus(1, 32'h4004 + 32'(8 * c), $urandom, 2'd0, 4'(((2 * c + 1) % 15) + 1));
      bus.dc_wr_ready = (c % 2) == 0;
      check("wrap_free_bound", 32'(bus.free_slots <= 8), 32'd1);
      tick();
    end
    clear_ways();
    bus.dc_wr_ready = 1'b1;
    repeat (12) tick();
    check("wrap_ack_count", 32'(ack_log.size()), 32'(accept_log.size()));
    for (int i = 0; i < ack_log.size() && i < accept_log.size(); i++)
      check("wrap_ack_order", 32'(ack_log[i]), 32'(accept_log[i]));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      clear_ways();
      for (int w = 0; w < N_WAY; w++)
        if ($urandom_range(0, 1) == 1)
          apply_stimulus(w, $urandom, $urandom, 2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)));
      bus.dc_wr_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    clear_ways();
    bus.dc_wr_ready = 1'b1;
    repeat (10) tick();
    check("rand_ack_count", 32'(ack_log.size()), 32'(accept_log.size()));

    // Reset while entries are pending: nothing drains or acks afterwards.
    do_reset();
    apply_stimulus(0, 32'h5000, 32'h11, 2'd2, 4'd1);
    apply_stimulus(1, 32'h5004, 32'h22, 2'd2, 4'd2);
    tick();
    clear_ways();
    apply_stimulus(0, 32'h5008, 32'h33, 2'd2, 4'd3);
    tick();
    clear_ways();
    check("midrst_pending", 32'(bus.free_slots), 32'd5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.dc_wr_ready = 1'b1;
    check("midrst_empty", 32'(bus.dc_wr_valid), 32'd0);
    check("midrst_free", 32'(bus.free_slots), 32'd8);
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_ack", 32'(bus.sq_ack_valid), 32'd0);
      tick();
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
